// File: rtl/bit_packer.sv
// bit_packer: gathers the valid lanes of each input vector, packs those bits LSB-first
// into OUT_W-bit words, and queues the finished words in a DEPTH-entry FIFO.
// Ports:
//   clk, reset_n          - rising-edge clock and asynchronous active-low reset
//   valid, bits           - per-lane valid mask and per-lane data bit, taken when in_ready=1
//   flush                 - zero-pads and emits the partial word (this cycle's bits go in first)
//   in_ready              - input is accepted this cycle (FIFO not full and no flush pending)
//   out_valid, out_ready  - FIFO head handshake; out_data is the head word
//   level                 - FIFO occupancy, 0..DEPTH
//   overflow, clr_ovf     - sticky flag for input dropped while in_ready=0, and its clear
// Latency: a word pushed at edge N is presented on out_data after edge N.
module bit_packer #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IN_W-1:0]          valid,
  input  logic [IN_W-1:0]          bits,
  input  logic                     flush,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NW = $clog2(IN_W + 1);
  localparam int CW = $clog2(OUT_W + IN_W + 1);
  localparam int SW = OUT_W + IN_W;

  typedef enum logic {ACC, FLUSH_PEND} state_t;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              overflow_q;

  logic [IN_W-1:0]   comp;
  logic [NW-1:0]     n;
  logic [CW-1:0]     total;
  logic [SW-1:0]     combined;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [OUT_W-1:0]  push_dat;

  // Compact the valid lanes lowest-first into comp[n-1:0]; n is the popcount.
  always_comb begin
    comp = '0;
    n    = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (valid[i]) begin
        comp = comp | (IN_W'(bits[i]) << n);
        n    = n + NW'(1);
      end
    end
  end

  // Bits above cnt_q in acc_q are always zero, so OR-ing in the shifted new
  // bits appends them and leaves everything above the last bit zero-padded.
  assign total    = cnt_q + CW'(n);
  assign combined = SW'(acc_q) | (SW'(comp) << cnt_q);
  assign full     = (level_q == LW'(DEPTH));
  assign in_ready = !full && (state_q == ACC);
  assign out_valid = (level_q != '0);
  assign out_data = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign pop      = out_valid && out_ready;
  assign drop     = !in_ready && ((|valid) || flush);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_dat = combined[OUT_W-1:0];
    case (state_q)
      ACC: begin
        if (in_ready) begin
          if (flush) begin
            if (total > CW'(OUT_W)) begin
              // More than one word's worth: emit the full word now, the padded
              // remainder once the FIFO has room.
              push    = 1'b1;
              acc_d   = OUT_W'(combined >> OUT_W);
              cnt_d   = total - CW'(OUT_W);
              state_d = FLUSH_PEND;
            end else if (total != '0) begin
              push  = 1'b1;
              acc_d = '0;
              cnt_d = '0;
            end
          end else if (total >= CW'(OUT_W)) begin
            push  = 1'b1;
            acc_d = OUT_W'(combined >> OUT_W);
            cnt_d = total - CW'(OUT_W);
          end else begin
            acc_d = combined[OUT_W-1:0];
            cnt_d = total;
          end
        end
      end
      FLUSH_PEND: begin
        if (!full) begin
          push     = 1'b1;
          push_dat = acc_q;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // Packing state machine, accumulator and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Output word FIFO; pushes only happen when not full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Testbench for bit_packer (IN_W=6, OUT_W=16, DEPTH=4): directed scenarios followed by
// randomized traffic, checked by a bit-queue reference model and an output word scoreboard.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_bit_packer;

  localparam int IN_W  = 6;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [IN_W-1:0]  valid;
  logic [IN_W-1:0]  bits;
  logic             flush;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [2:0]       level;
  logic             overflow;
  logic             clr_ovf;

  always #5 clk = ~clk;

  bit_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .bits(bits), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a plain stream of accepted bits, cut into words.
  bit               bitq[$];
  logic [OUT_W-1:0] expq[$];
  bit               ovf_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_accept(input logic [IN_W-1:0] v, input logic [IN_W-1:0] b,
                                       input logic f);
    logic [OUT_W-1:0] w;
    int k;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) bitq.push_back(b[i]);
    end
    while (bitq.size() >= OUT_W) begin
      w = '0;
      for (int j = 0; j < OUT_W; j++) w[j] = bitq.pop_front();
      expq.push_back(w);
    end
    if (f && bitq.size() > 0) begin
      w = '0;
      k = 0;
      while (bitq.size() > 0) begin
        w[k] = bitq.pop_front();
        k++;
      end
      expq.push_back(w);
    end
  endfunction

  // Monitor: checks the sticky flag, scores popped words, and feeds the model
  // with whatever the next rising edge will accept or drop.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("overflow", 32'(overflow), 32'(ovf_exp));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(expq.pop_front()));
        end
      end
      if (in_ready) begin
        model_accept(valid, bits, flush);
      end
      if (!in_ready && ((|valid) || flush)) ovf_exp = 1'b1;
      else if (clr_ovf) ovf_exp = 1'b0;
    end
  end

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic cyc(input logic [IN_W-1:0] v, input logic [IN_W-1:0] b, input logic f,
                     input logic c);
    valid   = v;
    bits    = b;
    flush   = f;
    clr_ovf = c;
    @(posedge clk);
    #1;
    valid   = '0;
    bits    = '0;
    flush   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc('0, '0, 1'b0, 1'b0);
  endtask

  logic [IN_W-1:0] rb;

  initial begin
    reset_n = 1'b1; valid = '0; bits = '0; flush = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Four vectors totalling 19 bits: one word 5A3F with 3 bits left over.
    cyc(6'b011111, 6'b111111, 1'b0, 1'b0);
    cyc(6'b100111, 6'b010001, 1'b0, 1'b0);
    cyc(6'b110111, 6'b010101, 1'b0, 1'b0);
    cyc(6'b110111, 6'b110101, 1'b0, 1'b0);
    chk("w1_out_valid", 32'(out_valid), 32'd1);
    chk("w1_out_data", 32'(out_data), 32'h5A3F);
    chk("w1_level", 32'(level), 32'd1);
    cyc(6'b000000, 6'b000000, 1'b1, 1'b0);
    chk("w2_level", 32'(level), 32'd2);
    chk("w2_head", 32'(out_data), 32'h5A3F);
    out_ready = 1'b1;
    idle(1);
    chk("w2_out_data", 32'(out_data), 32'h0007);
    idle(1);
    chk("w2_drained", 32'(level), 32'd0);

    // Fill the FIFO, drop one input, drain in order, clear the flag.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) cyc(6'h3F, 6'($urandom), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(6'h3F, 6'($urandom), 1'b0, 1'b0);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    idle(5);
    chk("drain_level", 32'(level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    cyc('0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    cyc('0, '0, 1'b1, 1'b0);
    idle(2);

    // cnt=14, flush with 5 more bits: full word, one FLUSH_PEND cycle, 3-bit remainder.
    out_ready = 1'b0;
    cyc(6'h3F, 6'($urandom), 1'b0, 1'b0);
    cyc(6'h3F, 6'($urandom), 1'b0, 1'b0);
    cyc(6'b000011, 6'($urandom), 1'b0, 1'b0);
    rb = 6'($urandom);
    cyc(6'b011111, rb, 1'b1, 1'b0);
    chk("fp_level", 32'(level), 32'd1);
    chk("fp_in_ready", 32'(in_ready), 32'd0);
    idle(1);
    chk("fp_done_in_ready", 32'(in_ready), 32'd1);
    chk("fp_done_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    idle(1);
    chk("fp_rem_word", 32'(out_data), {29'd0, rb[4], rb[3], rb[2]});
    idle(2);

    // Reset with level=3 and cnt=9 discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) cyc(6'h3F, 6'($urandom), 1'b0, 1'b0);
    cyc(6'b000111, 6'($urandom), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    bitq.delete();
    expq.delete();
    ovf_exp = 1'b0;
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    chk("post_rst_level", 32'(level), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc(6'(1 << $urandom_range(0, 5)), 6'($urandom), 1'b0, 1'b0);
    chk("single_lane_level", 32'(level), 32'd1);
    idle(3);
    chk("single_lane_hold", 32'(level), 32'd1);
    out_ready = 1'b1;
    idle(2);

    // Randomized traffic with random backpressure, flushes and clears.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(6'($urandom), 6'($urandom), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0));
    end
    out_ready = 1'b1;
    cyc('0, '0, 1'b1, 1'b0);
    idle(12);
    chk("final_level", 32'(level), 32'd0);
    chk("final_in_ready", 32'(in_ready), 32'd1);
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
